reg_wb_arbiter: RTL and testbench

Shares the single register-file write port (we3/ad3/wd3) between two write-back requesters: requester 0 (ALU result path) and requester 1 (load/multi-cycle unit). Each requester pushes (address, data) pairs through a valid/ready handshake into its own small FIFO. A round-robin arbiter drains one FIFO head per cycle into registered write-port outputs. A pending-write mask is exported for hazard/stall logic in the decode stage.

---
 rtl/reg_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the single register-file write port between the
// ALU write-back path (requester 0) and the load/multi-cycle path
// (requester 1). Each requester feeds a small FIFO. A round-robin arbiter
// drains one head per cycle into registered we3/ad3/wd3 outputs. A mask of
// pending destination registers is exported for decode-stage hazard logic.

// ---------------------------------------------------------------------------
// reg_wb_fifo: per-requester queue of {addr, data} write-back entries.
// The ready output is a flop. It reflects post-edge occupancy, so a FIFO
// that is full at an edge never accepts at that edge, even if it also pops.
// ---------------------------------------------------------------------------
module reg_wb_fifo #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_valid_i,
  input  logic [ADDR_WIDTH-1:0]      push_addr_i,
  input  logic [DATA_WIDTH-1:0]      push_data_i,
  input  logic                       pop_i,
  output logic                       ready_o,
  output logic                       empty_o,
  output logic [ADDR_WIDTH-1:0]      head_addr_o,
  output logic [DATA_WIDTH-1:0]      head_data_o,
  output logic [2**ADDR_WIDTH-1:0]   mask_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   count_q;
  logic [PW:0]   count_d;
  logic          ready_q;
  logic          push;

  // A push only happens when the registered ready was already high.
  assign push = push_valid_i && ready_q;

  // Distance of a storage slot from the read pointer. The subtraction wraps
  // naturally because the depth is a power of two.
  function automatic logic [PW-1:0] slot_age(input int slot);
    return PW'(slot) - rd_ptr_q;
  endfunction

  // Next occupancy from this edge's push and pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (push && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer, occupancy and ready registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      ready_q <= (count_d < (PW+1)'(FIFO_DEPTH));
      assert (!pop_i || count_q != '0)
        else $error("reg_wb_fifo: pop from empty queue");
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i) begin
    // NOTE: storage has no reset; occupancy decides which slots are meaningful, so stale contents are never observed.
    if (push) begin
      addr_mem[wr_ptr_q] <= push_addr_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

  assign ready_o     = ready_q;
  assign empty_o     = (count_q == '0);
  assign head_addr_o = addr_mem[rd_ptr_q];
  assign head_data_o = data_mem[rd_ptr_q];

  // One-hot OR of the destination of every occupied slot.
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ({1'b0, slot_age(i)} < count_q) begin
        mask_o[addr_mem[i]] = 1'b1;
      end
    end
  end

endmodule

// ---------------------------------------------------------------------------
// reg_wb_arbiter: top level.
// ---------------------------------------------------------------------------
module reg_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      r0_valid_i,
  output logic                      r0_ready_o,
  input  logic [ADDR_WIDTH-1:0]     r0_addr_i,
  input  logic [DATA_WIDTH-1:0]     r0_data_i,
  input  logic                      r1_valid_i,
  output logic                      r1_ready_o,
  input  logic [ADDR_WIDTH-1:0]     r1_addr_i,
  input  logic [DATA_WIDTH-1:0]     r1_data_i,
  output logic                      we3_o,
  output logic [ADDR_WIDTH-1:0]     ad3_o,
  output logic [DATA_WIDTH-1:0]     wd3_o,
  output logic [2**ADDR_WIDTH-1:0]  pend_mask_o
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic                  empty0;
  logic                  empty1;
  logic [ADDR_WIDTH-1:0] head_addr0;
  logic [ADDR_WIDTH-1:0] head_addr1;
  logic [DATA_WIDTH-1:0] head_data0;
  logic [DATA_WIDTH-1:0] head_data1;
  logic [NREG-1:0]       mask0;
  logic [NREG-1:0]       mask1;

  logic                  gnt_valid;
  logic                  gnt_sel;     // 0: requester 0, 1: requester 1
  logic                  pop0;
  logic                  pop1;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_data;

  logic                  last_q;      // requester granted most recently
  logic                  we3_q;
  logic [ADDR_WIDTH-1:0] ad3_q;
  logic [DATA_WIDTH-1:0] wd3_q;

  reg_wb_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo0 (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .push_valid_i (r0_valid_i),
    .push_addr_i  (r0_addr_i),
    .push_data_i  (r0_data_i),
    .pop_i        (pop0),
    .ready_o      (r0_ready_o),
    .empty_o      (empty0),
    .head_addr_o  (head_addr0),
    .head_data_o  (head_data0),
    .mask_o       (mask0)
  );

  reg_wb_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo1 (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .push_valid_i (r1_valid_i),
    .push_addr_i  (r1_addr_i),
    .push_data_i  (r1_data_i),
    .pop_i        (pop1),
    .ready_o      (r1_ready_o),
    .empty_o      (empty1),
    .head_addr_o  (head_addr1),
    .head_data_o  (head_data1),
    .mask_o       (mask1)
  );

  // Round-robin grant from FIFO state only; a tie goes to the requester not granted last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_sel   = 1'b0;
    if (!empty0 && !empty1) begin
      gnt_valid = 1'b1;
      gnt_sel   = ~last_q;
    end else if (!empty0) begin
      gnt_valid = 1'b1;
      gnt_sel   = 1'b0;
    end else if (!empty1) begin
      gnt_valid = 1'b1;
      gnt_sel   = 1'b1;
    end
  end

  assign pop0     = gnt_valid && !gnt_sel;
  assign pop1     = gnt_valid &&  gnt_sel;
  assign gnt_addr = gnt_sel ? head_addr1 : head_addr0;
  assign gnt_data = gnt_sel ? head_data1 : head_data0;

  // Round-robin history; moves only when something is granted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= 1'b1;
    end else if (gnt_valid) begin
      last_q <= gnt_sel;
    end
  end

  // Registered write port. Writes to x0 are popped but never enabled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we3_q <= 1'b0;
      ad3_q <= '0;
      wd3_q <= '0;
    end else if (gnt_valid) begin
      we3_q <= (gnt_addr != '0);
      ad3_q <= gnt_addr;
      wd3_q <= gnt_data;
    end else begin
      we3_q <= 1'b0;
    end
  end

  assign we3_o = we3_q;
  assign ad3_o = ad3_q;
  assign wd3_o = wd3_q;

  // Pending mask from flops only: queued entries plus the write on the port; x0 never pends.
  always_comb begin
    pend_mask_o = mask0 | mask1;
    if (we3_q) begin
      pend_mask_o[ad3_q] = 1'b1;
    end
    pend_mask_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared every cycle against a queue-based model.
module tb_reg_wb_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int NREG  = 2**AW;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic            clk_i;
  logic            rst_n_i;
  logic            r0_valid_i, r1_valid_i;
  logic            r0_ready_o, r1_ready_o;
  logic [AW-1:0]   r0_addr_i, r1_addr_i;
  logic [DW-1:0]   r0_data_i, r1_data_i;
  logic            we3_o;
  logic [AW-1:0]   ad3_o;
  logic [DW-1:0]   wd3_o;
  logic [NREG-1:0] pend_mask_o;

  reg_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .r0_valid_i  (r0_valid_i),
    .r0_ready_o  (r0_ready_o),
    .r0_addr_i   (r0_addr_i),
    .r0_data_i   (r0_data_i),
    .r1_valid_i  (r1_valid_i),
    .r1_ready_o  (r1_ready_o),
    .r1_addr_i   (r1_addr_i),
    .r1_data_i   (r1_data_i),
    .we3_o       (we3_o),
    .ad3_o       (ad3_o),
    .wd3_o       (wd3_o),
    .pend_mask_o (pend_mask_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Register file fed by the DUT's write port, plus a count of issued writes.
  logic [DW-1:0] rf [NREG];
  int            wr_count = 0;
  always @(posedge clk_i) begin
    if (we3_o) begin
      rf[ad3_o] <= wd3_o;
      wr_count  <= wr_count + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  ent_t          m_q0[$];
  ent_t          m_q1[$];
  bit            m_last;
  bit            m_rdy0, m_rdy1;
  bit            m_we;
  logic [AW-1:0] m_ad;
  logic [DW-1:0] m_wd;
  bit            m_acc0, m_acc1;

  task automatic model_reset();
    m_q0.delete();
    m_q1.delete();
    m_last = 1'b1;
    m_rdy0 = 1'b0;
    m_rdy1 = 1'b0;
    m_we   = 1'b0;
    m_ad   = '0;
    m_wd   = '0;
  endtask

  task automatic model_edge(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                            input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bit   g;
    bit   sel;
    ent_t e;
    m_acc0 = v0 && m_rdy0;
    m_acc1 = v1 && m_rdy1;
    g   = 1'b0;
    sel = 1'b0;
    if (m_q0.size() > 0 && m_q1.size() > 0) begin
      g   = 1'b1;
      sel = (m_last == 1'b0);
    end else if (m_q0.size() > 0) begin
      g = 1'b1;
    end else if (m_q1.size() > 0) begin
      g   = 1'b1;
      sel = 1'b1;
    end
    if (g) begin
      if (sel) e = m_q1.pop_front();
      else     e = m_q0.pop_front();
      m_ad   = e.a;
      m_wd   = e.d;
      m_we   = (e.a != 0);
      m_last = sel;
    end else begin
      m_we = 1'b0;
    end
    if (m_acc0) m_q0.push_back('{a: a0, d: d0});
    if (m_acc1) m_q1.push_back('{a: a1, d: d1});
    m_rdy0 = (m_q0.size() < DEPTH);
    m_rdy1 = (m_q1.size() < DEPTH);
  endtask

  function automatic logic [NREG-1:0] exp_mask();
    logic [NREG-1:0] m = '0;
    foreach (m_q0[i]) m[m_q0[i].a] = 1'b1;
    foreach (m_q1[i]) m[m_q1[i].a] = 1'b1;
    if (m_we) m[m_ad] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".rdy0"}, 64'(r0_ready_o), 64'(m_rdy0));
    check({tag, ".rdy1"}, 64'(r1_ready_o), 64'(m_rdy1));
    check({tag, ".we3"},  64'(we3_o),      64'(m_we));
    check({tag, ".ad3"},  64'(ad3_o),      64'(m_ad));
    check({tag, ".wd3"},  64'(wd3_o),      64'(m_wd));
    check({tag, ".pend"}, 64'(pend_mask_o), 64'(exp_mask()));
  endtask

  // One clock: drive after a falling edge, update the model at the rising
  // edge, compare at the next falling edge.
  task automatic step(input string tag,
                      input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    r0_valid_i = v0; r0_addr_i = a0; r0_data_i = d0;
    r1_valid_i = v1; r1_addr_i = a1; r1_data_i = d1;
    @(posedge clk_i);
    model_edge(v0, a0, d0, v1, a1, d1);
    @(negedge clk_i);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rdy0"}, 64'(r0_ready_o), 64'd0);
    check({tag, ".rdy1"}, 64'(r1_ready_o), 64'd0);
    check({tag, ".we3"},  64'(we3_o),      64'd0);
    check({tag, ".ad3"},  64'(ad3_o),      64'd0);
    check({tag, ".wd3"},  64'(wd3_o),      64'd0);
    check({tag, ".pend"}, 64'(pend_mask_o), 64'd0);
  endtask

  // Asserts reset at the current time, holds it for three cycles and
  // releases it on a falling edge.
  task automatic do_reset(input string tag);
    rst_n_i    = 1'b0;
    r0_valid_i = 1'b0;
    r1_valid_i = 1'b0;
    #1;
    check_all_zero({tag, ".async"});
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero({tag, ".held"});
    rst_n_i = 1'b1;
    model_reset();
    #1;
    check_all_zero({tag, ".release"});
  endtask

  // ---------------- requester drivers ----------------
  bit            rq_v[2];
  logic [AW-1:0] rq_a[2];
  logic [DW-1:0] rq_d[2];
  int            rq_cnt[2];

  // Each requester raises valid with probability pct, up to quota items,
  // holding valid and payload until the model says the item was accepted.
  task automatic traffic(input string tag, input int cycles, input int pct,
                         input int quota, input bit directed);
    for (int c = 0; c < cycles; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!rq_v[n] && rq_cnt[n] < quota && int'($urandom_range(99)) < pct) begin
          rq_v[n] = 1'b1;
          if (directed) begin
            rq_a[n] = AW'(n * 8 + rq_cnt[n] + 1);
            rq_d[n] = 32'hA000_0000 | 32'(n << 8) | 32'(rq_cnt[n]);
          end else begin
            rq_a[n] = AW'($urandom);
            rq_d[n] = $urandom;
          end
          rq_cnt[n]++;
        end
      end
      step(tag, rq_v[0], rq_a[0], rq_d[0], rq_v[1], rq_a[1], rq_d[1]);
      if (m_acc0) rq_v[0] = 1'b0;
      if (m_acc1) rq_v[1] = 1'b0;
    end
  endtask

  task automatic drivers_clear();
    for (int n = 0; n < 2; n++) begin
      rq_v[n]   = 1'b0;
      rq_cnt[n] = 0;
      rq_a[n]   = '0;
      rq_d[n]   = '0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int guard;
    rst_n_i    = 1'b0;
    r0_valid_i = 1'b0; r0_addr_i = '0; r0_data_i = '0;
    r1_valid_i = 1'b0; r1_addr_i = '0; r1_data_i = '0;
    drivers_clear();
    model_reset();
    @(negedge clk_i);

    // Reset, then ready rises after the first edge.
    do_reset("rst");
    idle("rst.first", 1);
    check("rst.rdy0_up", 64'(r0_ready_o), 64'd1);
    check("rst.rdy1_up", 64'(r1_ready_o), 64'd1);

    // Single write to x5.
    step("single.e0", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
    check("single.pend_e0", 64'(pend_mask_o), 64'h20);
    check("single.we_e0", 64'(we3_o), 64'd0);
    idle("single.e1", 1);
    check("single.we_e1", 64'(we3_o), 64'd1);
    check("single.ad_e1", 64'(ad3_o), 64'd5);
    check("single.wd_e1", 64'(wd3_o), 64'hDEAD_BEEF);
    check("single.pend_e1", 64'(pend_mask_o), 64'h20);
    idle("single.e2", 1);
    check("single.we_e2", 64'(we3_o), 64'd0);
    check("single.pend_e2", 64'(pend_mask_o), 64'h0);

    // Tie on x3 right after reset: requester 0 first, requester 1 last.
    @(negedge clk_i);
    do_reset("tie.rst");
    idle("tie.first", 1);
    step("tie.e0", 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    check("tie.pend_e0", 64'(pend_mask_o[3]), 64'd1);
    idle("tie.e1", 1);
    check("tie.wd_e1", 64'(wd3_o), 64'h11);
    check("tie.pend_e1", 64'(pend_mask_o[3]), 64'd1);
    idle("tie.e2", 1);
    check("tie.wd_e2", 64'(wd3_o), 64'h22);
    check("tie.pend_e2", 64'(pend_mask_o[3]), 64'd1);
    idle("tie.drain", 2);
    check("tie.rf3", 64'(rf[3]), 64'h22);

    // Saturation: 8 writes per requester, held valid under backpressure.
    drivers_clear();
    base = wr_count;
    traffic("sat", 30, 100, 8, 1'b1);
    check("sat.count", 64'(wr_count - base), 64'd16);
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("sat.rf%0d", n * 8 + k + 1), 64'(rf[n * 8 + k + 1]),
              64'(32'hA000_0000 | 32'(n << 8) | 32'(k)));
      end
    end

    // x0 write: popped and discarded, never enabled.
    base = wr_count;
    step("x0.e0", 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    check("x0.pend_e0", 64'(pend_mask_o), 64'h0);
    idle("x0.drain", 3);
    check("x0.count", 64'(wr_count - base), 64'd0);
    check("x0.rdy1", 64'(r1_ready_o), 64'd1);

    // Reset mid-flight while the write port is busy.
    drivers_clear();
    traffic("mf.fill", 3, 100, 4, 1'b1);
    guard = 0;
    while (we3_o !== 1'b1 && guard < 20) begin
      idle("mf.wait", 1);
      guard++;
    end
    check("mf.we3_seen", 64'(we3_o), 64'd1);
    #2;
    drivers_clear();
    do_reset("mf.rst");
    base = wr_count;
    idle("mf.after", 6);
    check("mf.no_stale", 64'(wr_count - base), 64'd0);

    // Randomized traffic, including x0 and same-register collisions.
    drivers_clear();
    traffic("rand", 3000, 60, 1 << 30, 1'b0);
    drivers_clear();
    idle("rand.drain", 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1);
  end

endmodule
